xnor_parity_sequencer: RTL and testbench
========================================

Name: xnor_parity_sequencer

Overview:
- Computes the XOR parity of a WIDTH-bit word by time-sharing one two-stage XNOR cell, two bits per clock.
- The cell has inputs a, b, c and outputs d = ~(a^b) and e = ~(c^d); e therefore equals a^b^c.
- The cell is instantiated exactly once and is the block's only parity logic.
- Sits between a word source (start/data handshake) and a checker consuming parity and error flag.

Parameters:
- WIDTH, 8, word width in bits; must be even and ≥ 2.
- CW, $clog2(WIDTH/2)+1, step-counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request to process data_in; sampled only in IDLE or DONE.
- data_in  input  WIDTH  word to check; captured on the accepting edge.
- exp_parity  input  1  expected parity bit; captured with data_in.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: result valid.
- parity_out  output  1  XOR of all bits of the captured word; held until next accept.
- parity_err  output  1  parity_out ^ captured exp_parity; held like parity_out.
- step_cnt  output  CW  number of completed steps in the current run.

Behaviour:
- Reset: when rst_n=0 at a rising edge, state <= IDLE and busy, done, parity_out, parity_err, step_cnt, acc and shift register all become 0. Reset overrides everything, including a run in progress; the aborted run produces no done.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 → accept: shreg <= data_in, exp_q <= exp_parity, acc <= 0, step_cnt <= 0, state <= RUN.
- RUN:
  - busy=1; start is ignored, with no queuing.
  - Cell wiring: a=acc, b=shreg[0], c=shreg[1].
  - Each edge: acc <= e, shreg <= shreg >> 2 (zero fill), step_cnt <= step_cnt+1.
  - On the step where step_cnt == WIDTH/2-1: parity_out <= e, parity_err <= e ^ exp_q, done <= 1, state <= DONE.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - Next edge: start=1 → accept as in IDLE (back-to-back runs allowed); otherwise → IDLE. done returns to 0 either way.
- Latency: if start is accepted at edge k, done is high in the cycle after edge k+WIDTH/2. Sustained throughput is one word per WIDTH/2+1 cycles.
- Holding: parity_out and parity_err change only on the final RUN step. They stay unchanged through IDLE, through DONE, and through the next run until its final step. They are not cleared on accept.
- step_cnt: resets to 0 on accept, reaches WIDTH/2 on the final step, and holds that value in DONE and IDLE.
- Input stability: data_in and exp_parity are don't-care outside the accepting edge.
- WIDTH=2: RUN lasts a single cycle.

Test Plan:
- WIDTH=8, reset, then start=1 with data_in=8'hA5, exp_parity=0 → busy high for 4 cycles; done pulses once, 4 edges after accept; parity_out=0, parity_err=0, step_cnt=4.
- data_in=8'h07, exp_parity=0 → parity_out=1, parity_err=1. Repeat with exp_parity=1 → parity_err=0.
- Hold start=1 continuously with 8'hFF then 8'h01 → second accept happens in the DONE cycle. Results: 0 after the first done, 1 after the second. done pulses are 5 cycles apart; start is never accepted while busy.
- Change start and data_in randomly during RUN of 8'h80 → ignored; result parity_out=1, exactly one done.
- Drive rst_n=0 for one edge at step 2 of a run with 8'h03 → all outputs 0 next cycle, no done pulse. A new start with 8'h03 then gives parity_out=0.
- WIDTH=2 instance, data_in=2'b10 → done 1 edge after accept, parity_out=1, step_cnt=1.

Source files
------------

// File: rtl/xnor_parity_sequencer.sv
// xnor_parity_sequencer: word parity via one time-shared two-stage XNOR cell, two bits/clock.
// Revision: 1.0
`default_nettype none

module xnor_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic e
);
  logic d;

  assign d = ~(a ^ b);
  assign e = ~(c ^ d);
endmodule

module xnor_parity_sequencer #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH/2) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             exp_parity,
  output logic             busy,
  output logic             done,
  output logic             parity_out,
  output logic             parity_err,
  output logic [CW-1:0]    step_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             acc_q;
  logic             acc_d;
  logic             exp_q;
  logic             busy_q;
  logic             done_q;
  logic             parity_q;
  logic             err_q;
  logic [CW-1:0]    step_cnt_q;
  logic [CW-1:0]    step_cnt_d;
  logic             last_step;

  // Running parity folds the two lowest unconsumed bits into acc each step.
  xnor_cell u_cell (
    .a (acc_q),
    .b (shreg_q[0]),
    .c (shreg_q[1]),
    .e (acc_d)
  );

  assign shreg_d    = shreg_q >> 2;
  assign step_cnt_d = step_cnt_q + CW'(1);
  assign last_step  = (step_cnt_q == CW'(WIDTH/2 - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      acc_q      <= 1'b0;
      exp_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      parity_q   <= 1'b0;
      err_q      <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            shreg_q    <= data_in;
            exp_q      <= exp_parity;
            acc_q      <= 1'b0;
            step_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q      <= acc_d;
          shreg_q    <= shreg_d;
          step_cnt_q <= step_cnt_d;
          if (last_step) begin
            parity_q <= acc_d;
            err_q    <= acc_d ^ exp_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign parity_out = parity_q;
  assign parity_err = err_q;
  assign step_cnt   = step_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_xnor_parity_sequencer.sv
// tb_xnor_parity_sequencer: scoreboard bench for xnor_parity_sequencer (WIDTH=8 and WIDTH=2).
// Revision: 1.0
`default_nettype none

module tb_xnor_parity_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       exp_parity;
  logic [7:0] data_in;
  logic       busy, done, parity_out, parity_err;
  logic [2:0] step_cnt;

  logic       start2, exp2;
  logic [1:0] data2;
  logic       busy2, done2, par2, err2;
  logic [0:0] step2;

  always #5 clk = ~clk;

  xnor_parity_sequencer #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data_in    (data_in),
    .exp_parity (exp_parity),
    .busy       (busy),
    .done       (done),
    .parity_out (parity_out),
    .parity_err (parity_err),
    .step_cnt   (step_cnt)
  );

  xnor_parity_sequencer #(.WIDTH(2)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start2),
    .data_in    (data2),
    .exp_parity (exp2),
    .busy       (busy2),
    .done       (done2),
    .parity_out (par2),
    .parity_err (err2),
    .step_cnt   (step2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic par;
    logic err;
  } exp_t;
  exp_t sb_q[$];

  // Cycle-level reference for the WIDTH=8 instance: 0 idle, 1 run, 2 done.
  int         m_state = 0;
  logic       m_busy = 1'b0, m_done = 1'b0, m_par = 1'b0, m_err = 1'b0, m_exp = 1'b0;
  logic [2:0] m_cnt = 3'd0;
  logic [7:0] m_word = 8'd0;
  int         cyc = 0;
  int         done_cnt = 0, done_cyc_last = 0, done_cyc_prev = 0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_state <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_par <= 1'b0; m_err <= 1'b0; m_cnt <= 3'd0;
      sb_q.delete();
    end else if (m_state == 1) begin
      m_cnt <= m_cnt + 3'd1;
      if (m_cnt == 3'd3) begin
        m_state <= 2; m_busy <= 1'b0; m_done <= 1'b1;
        m_par <= ^m_word; m_err <= (^m_word) ^ m_exp;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_state <= 1; m_busy <= 1'b1; m_cnt <= 3'd0;
        m_word <= data_in; m_exp <= exp_parity;
        sb_q.push_back('{par: ^data_in, err: (^data_in) ^ exp_parity});
      end else begin
        m_state <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("step_cnt", step_cnt, m_cnt);
      check("parity_out", parity_out, m_par);
      check("parity_err", parity_err, m_err);
      if (done) begin
        check("sb_has_entry", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          check("sb_parity", parity_out, sb_q[0].par);
          check("sb_err", parity_err, sb_q[0].err);
          check("sb_step", step_cnt, 4);
          void'(sb_q.pop_front());
        end
        done_cnt      <= done_cnt + 1;
        done_cyc_prev <= done_cyc_last;
        done_cyc_last <= cyc;
      end
    end
  end

  task automatic run_word(input logic [7:0] d, input logic e);
    start = 1'b1; data_in = d; exp_parity = e;
    @(negedge clk);
    start = 1'b0; data_in = 8'($urandom); exp_parity = 1'($urandom);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; data_in = '0; exp_parity = 1'b0;
    start2 = 1'b0; data2 = '0; exp2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_par", parity_out, 0);
    check("rst_err", parity_err, 0);
    check("rst_step", step_cnt, 0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    run_word(8'hA5, 1'b0);
    check("a5_par", parity_out, 0);
    check("a5_err", parity_err, 0);
    check("a5_step", step_cnt, 4);
    run_word(8'h07, 1'b0);
    check("07_par", parity_out, 1);
    check("07_err", parity_err, 1);
    run_word(8'h07, 1'b1);
    check("07e_err", parity_err, 0);

    // start held high: second word is accepted in the DONE cycle
    d0 = done_cnt;
    start = 1'b1; data_in = 8'hFF; exp_parity = 1'b0;
    @(negedge clk);
    data_in = 8'h01;
    repeat (5) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_dones", done_cnt - d0, 2);
    check("b2b_spacing", done_cyc_last - done_cyc_prev, 5);
    check("b2b_par", parity_out, 1);

    d0 = done_cnt;
    start = 1'b1; data_in = 8'h80; exp_parity = 1'b0;
    @(negedge clk);
    repeat (4) begin
      start = 1'($urandom); data_in = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("ign_dones", done_cnt - d0, 1);
    check("ign_par", parity_out, 1);

    // reset lands on the second RUN step
    d0 = done_cnt;
    start = 1'b1; data_in = 8'h03; exp_parity = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_par", parity_out, 0);
    check("abort_err", parity_err, 0);
    check("abort_step", step_cnt, 0);
    repeat (6) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    run_word(8'h03, 1'b0);
    check("03_par", parity_out, 0);
    check("03_dones", done_cnt - d0, 1);

    start2 = 1'b1; data2 = 2'b10; exp2 = 1'b0;
    @(negedge clk);
    start2 = 1'b0;
    check("w2_busy", busy2, 1);
    check("w2_early", done2, 0);
    @(negedge clk);
    check("w2_done", done2, 1);
    check("w2_busy_off", busy2, 0);
    check("w2_par", par2, 1);
    check("w2_err", err2, 1);
    check("w2_step", step2, 1);
    @(negedge clk);
    check("w2_done_off", done2, 0);
    check("w2_hold", par2, 1);
    start2 = 1'b1; data2 = 2'b11; exp2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    check("w2b_done", done2, 1);
    check("w2b_par", par2, 0);
    check("w2b_err", err2, 1);

    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
